pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and fetch-control block that drives the `pc` address into the instruction ROM/decoder. It consumes the decoded `opcode` back, and decides the next `pc`: sequential, jump, conditional branch, or halt. It runs the core from a `start` pulse until HALT and reports completion and a retired-instruction count to the testbench/top level.

## Interface
Parameters:
- `PC_W`, 16: width of `pc`, `target` and `instr_count`.
- `START_PC`, 0: address loaded on `start`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin execution.
- `stall`  in  1  hold the current `pc`; the current instruction does not retire.
- `opcode`  in  4  decoded opcode for the current `pc` (same cycle, combinational from ROM).
- `target`  in  PC_W  jump/branch target, read from the register file for the current instruction.
- `eq`  in  1  ALU compare result, operands equal.
- `lt`  in  1  ALU compare result, operand1 < operand2 (signed).
- `pc`  out  PC_W  current instruction address.
- `running`  out  1  high in RUN state.
- `done`  out  1  high in HALTED state.
- `fault`  out  1  sticky; set on `pc` wrap-around.
- `retire`  out  1  one-cycle pulse per retired instruction.
- `instr_count`  out  PC_W  retired instructions since `start`; saturates at all-ones.

## Operation
States:
- IDLE (reset state).
- RUN.
- HALTED.

Reset values: `pc`=START_PC, state IDLE, `running`=0, `done`=0, `fault`=0, `retire`=0, `instr_count`=0.

IDLE:
- `start`=1 → RUN, `pc`←START_PC, `instr_count`←0, `fault`←0.
- Other inputs ignored.

RUN, with `stall`=1:
- `pc`, `instr_count` and state hold.
- `retire`=0.
- `opcode` is ignored.

RUN, with `stall`=0: the instruction retires (`retire`=1 this cycle, `instr_count`+1 at the edge) and the next `pc` is chosen by opcode:
- JMP 4'b0010: `pc`←`target`.
- BNE 4'b1010: `pc`←`target` if `eq`=0, else `pc`+1.
- BEQ 4'b1011: `pc`←`target` if `eq`=1, else `pc`+1.
- BLT 4'b1100: `pc`←`target` if `lt`=1, else `pc`+1.
- HALT 4'b1110: `pc` holds, state→HALTED. HALT counts as retired.
- TBA 4'b1111 and all other opcodes: `pc`←`pc`+1.

Wrap-around:
- A sequential increment from all-ones sets `fault`=1, leaves `pc` at all-ones and goes to HALTED. The instruction still retires.
- A jump or branch to any address, including 0, is legal.

HALTED:
- `done`=1, `pc` holds.
- `start`=1 → RUN with the same effects as from IDLE: `done` clears, `fault` and `instr_count` clear.

Other rules:
- `start` while in RUN is ignored.
- `stall` and `start` together in IDLE/HALTED: start wins; `stall` only matters in RUN.
- `instr_count` saturates at 2^PC_W−1 and never wraps.
- Reset asserted mid-run returns immediately (asynchronously) to IDLE with the reset values above.

## Timing
- All state, `pc`, `fault` and `instr_count` are registered on `clk` rising edge.
- `running`/`done` are decoded from the state register.
- `retire` is combinational: `running & ~stall`.
- ROM/decoder path is zero-latency, so `opcode` for `pc` is valid in the same cycle. Throughput is one instruction per unstalled cycle.
- Jump/branch is taken at the edge ending the branch cycle, and the target instruction is presented the next cycle. There is no delay slot and no bubble.
- First instruction: `pc`=START_PC is valid in the cycle after `start` is sampled; `running`=1 from that cycle.
- `eq`, `lt` and `target` are sampled only in cycles where the current opcode uses them and `stall`=0.
- `rst_n` deassertion is synchronized externally; the block only assumes async assert.

## Test plan
- **Linear program:** reset, `start` pulse, opcodes 0100, 1101, 0100, 1001, 0110, 1110 at pc 0–5 → `pc` steps 0..5, `retire` high 6 cycles, `done`=1 with `pc`=5, `instr_count`=6.
- **Branches:** at pc 3, BEQ with `target`=0x0010, `eq`=1 → next `pc`=0x0010. Repeat with `eq`=0 → `pc`=4. BLT with `lt`=1, `target`=0 → `pc`=0. BNE with `eq`=1 → `pc`=4.
- **Stall:** assert `stall` for 3 cycles at `pc`=2 holding a JMP with `target`=7 → `pc` stays 2, `instr_count` unchanged, `retire`=0. On release `pc`=7 next cycle.
- **Wrap:** JMP to 0xFFFF, then NOP opcode 0111 → `fault`=1, `done`=1, `pc`=0xFFFF. A new `start` clears `fault` and sets `pc`=0.
- **Reset mid-run:** drop `rst_n` at `pc`=4 between edges → `pc`=0, `running`=0, `instr_count`=0 immediately. `start` while RUN → no effect on `pc`.
- **Saturation:** with PC_W=4, loop a JMP to itself for 20 cycles → `instr_count` stops at 15.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter / fetch control: steps, jumps, branches or halts on the decoded opcode.
// Latency: next pc registered at each unstalled edge; retire is combinational in the same cycle.
// Backpressure: stall holds pc, count and state and suppresses retire; start is ignored while running.
module pc_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic [3:0]      opcode,
  input  logic [PC_W-1:0] target,
  input  logic            eq,
  input  logic            lt,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            fault,
  output logic            retire,
  output logic [PC_W-1:0] instr_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1110;

  localparam logic [PC_W-1:0] ALL_ONES = '1;

  logic [1:0]      state_q, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [PC_W-1:0] cnt_q, cnt_n;
  logic            fault_q, fault_n;
  logic            take_target;

  // Redirect decision: jumps always, branches on the ALU compare flags.
  always_comb begin
    take_target = 1'b0;
    case (opcode)
      OP_JMP:  take_target = 1'b1;
      OP_BNE:  take_target = ~eq;
      OP_BEQ:  take_target = eq;
      OP_BLT:  take_target = lt;
      default: take_target = 1'b0;
    endcase
  end

  // Next-state, next-pc, retire counter and wrap fault.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    cnt_n   = cnt_q;
    fault_n = fault_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_n = ST_RUN;
          pc_n    = START_PC;
          cnt_n   = '0;
          fault_n = 1'b0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          // Every unstalled instruction retires, HALT and the wrapping one included.
          if (cnt_q != ALL_ONES) cnt_n = cnt_q + 1'b1;
          if (opcode == OP_HALT) begin
            state_n = ST_HALTED;
          end else if (take_target) begin
            pc_n = target;
          end else if (pc_q == ALL_ONES) begin
            // Sequential fall-off past the top of the address space: stop with pc parked.
            fault_n = 1'b1;
            state_n = ST_HALTED;
          end else begin
            pc_n = pc_q + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Architectural registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      cnt_q   <= cnt_n;
      fault_q <= fault_n;
    end
  end

  assign pc          = pc_q;
  assign running     = (state_q == ST_RUN);
  assign done        = (state_q == ST_HALTED);
  assign fault       = fault_q;
  assign retire      = running & ~stall;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for straight-line and branch flow,
// plus hand sequences for async reset mid-run and counter saturation (PC_W=4 instance).
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_pc_sequencer;

  localparam logic [3:0] JMP = 4'b0010, BNE = 4'b1010, BEQ = 4'b1011, BLT = 4'b1100;
  localparam logic [3:0] HLT = 4'b1110, NOP = 4'b0111;

  logic        clk, rst_n, start, stall, eq, lt;
  logic [3:0]  opcode;
  logic [15:0] target, pc, instr_count;
  logic        running, done, fault, retire;

  logic [3:0]  target4, pc4, cnt4;
  logic        running4, done4, fault4, retire4;

  assign target4 = target[3:0];

  pc_sequencer #(.PC_W(16), .START_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .opcode(opcode),
    .target(target), .eq(eq), .lt(lt), .pc(pc), .running(running), .done(done),
    .fault(fault), .retire(retire), .instr_count(instr_count)
  );

  pc_sequencer #(.PC_W(4), .START_PC(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .opcode(opcode),
    .target(target4), .eq(eq), .lt(lt), .pc(pc4), .running(running4), .done(done4),
    .fault(fault4), .retire(retire4), .instr_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start, stall;
    logic [3:0]  op;
    logic [15:0] tgt;
    logic        eq, lt;
    logic [15:0] e_pc;
    logic        e_run, e_done, e_ret;
    logic [15:0] e_cnt;
    logic        e_flt;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sl, input logic [3:0] op,
                              input logic [15:0] tgt, input logic e, input logic l,
                              input logic [15:0] epc, input logic erun, input logic edone,
                              input logic eret, input logic [15:0] ecnt, input logic eflt);
    vec_t v;
    v.start = st; v.stall = sl; v.op = op; v.tgt = tgt; v.eq = e; v.lt = l;
    v.e_pc = epc; v.e_run = erun; v.e_done = edone; v.e_ret = eret;
    v.e_cnt = ecnt; v.e_flt = eflt;
    return v;
  endfunction

  vec_t vecs[32];

  initial begin
    // Outputs listed are those seen during the cycle in which the inputs are applied.
    //            st sl op    tgt      eq lt  pc       run dn ret cnt  flt
    vecs[0]  = mk(1, 0, 4'h0, 16'h0,   0, 0,  16'h0,   0,  0, 0,  0,  0);
    vecs[1]  = mk(0, 0, 4'h4, 16'h0,   0, 0,  16'h0,   1,  0, 1,  0,  0);
    vecs[2]  = mk(0, 0, 4'hD, 16'h0,   0, 0,  16'h1,   1,  0, 1,  1,  0);
    vecs[3]  = mk(0, 0, 4'h4, 16'h0,   0, 0,  16'h2,   1,  0, 1,  2,  0);
    vecs[4]  = mk(0, 0, 4'h9, 16'h0,   0, 0,  16'h3,   1,  0, 1,  3,  0);
    vecs[5]  = mk(0, 0, 4'h6, 16'h0,   0, 0,  16'h4,   1,  0, 1,  4,  0);
    vecs[6]  = mk(0, 0, HLT,  16'h0,   0, 0,  16'h5,   1,  0, 1,  5,  0);
    vecs[7]  = mk(0, 0, 4'h0, 16'h0,   0, 0,  16'h5,   0,  1, 0,  6,  0);
    vecs[8]  = mk(1, 0, 4'h0, 16'h0,   0, 0,  16'h5,   0,  1, 0,  6,  0);
    vecs[9]  = mk(0, 0, 4'h0, 16'h0,   0, 0,  16'h0,   1,  0, 1,  0,  0);
    vecs[10] = mk(0, 0, 4'hF, 16'h0,   0, 0,  16'h1,   1,  0, 1,  1,  0);
    vecs[11] = mk(0, 0, 4'h0, 16'h0,   0, 0,  16'h2,   1,  0, 1,  2,  0);
    vecs[12] = mk(0, 0, BEQ,  16'h10,  1, 0,  16'h3,   1,  0, 1,  3,  0);
    vecs[13] = mk(0, 0, JMP,  16'h3,   0, 0,  16'h10,  1,  0, 1,  4,  0);
    vecs[14] = mk(0, 0, BEQ,  16'h10,  0, 1,  16'h3,   1,  0, 1,  5,  0);
    vecs[15] = mk(0, 0, JMP,  16'h3,   0, 0,  16'h4,   1,  0, 1,  6,  0);
    vecs[16] = mk(0, 0, BLT,  16'h0,   0, 1,  16'h3,   1,  0, 1,  7,  0);
    vecs[17] = mk(0, 0, JMP,  16'h3,   0, 0,  16'h0,   1,  0, 1,  8,  0);
    vecs[18] = mk(0, 0, BNE,  16'h10,  1, 0,  16'h3,   1,  0, 1,  9,  0);
    vecs[19] = mk(0, 0, BNE,  16'h20,  0, 0,  16'h4,   1,  0, 1,  10, 0);
    vecs[20] = mk(0, 0, BLT,  16'h0,   1, 0,  16'h20,  1,  0, 1,  11, 0);
    vecs[21] = mk(1, 0, 4'h0, 16'h0,   0, 0,  16'h21,  1,  0, 1,  12, 0);
    vecs[22] = mk(0, 0, JMP,  16'h2,   0, 0,  16'h22,  1,  0, 1,  13, 0);
    vecs[23] = mk(0, 1, JMP,  16'h7,   0, 0,  16'h2,   1,  0, 0,  14, 0);
    vecs[24] = mk(0, 1, JMP,  16'h7,   0, 0,  16'h2,   1,  0, 0,  14, 0);
    vecs[25] = mk(0, 1, JMP,  16'h7,   0, 0,  16'h2,   1,  0, 0,  14, 0);
    vecs[26] = mk(0, 0, JMP,  16'h7,   0, 0,  16'h2,   1,  0, 1,  14, 0);
    vecs[27] = mk(0, 0, JMP,  16'hFFFF,0, 0,  16'h7,   1,  0, 1,  15, 0);
    vecs[28] = mk(0, 0, NOP,  16'h0,   0, 0,  16'hFFFF,1,  0, 1,  16, 0);
    vecs[29] = mk(1, 1, 4'h0, 16'h0,   0, 0,  16'hFFFF,0,  1, 0,  17, 1);
    vecs[30] = mk(0, 0, HLT,  16'h0,   0, 0,  16'h0,   1,  0, 1,  0,  0);
    vecs[31] = mk(0, 0, 4'h0, 16'h0,   0, 0,  16'h0,   0,  1, 0,  1,  0);

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; opcode = 4'h0;
    target = 16'h0; eq = 1'b0; lt = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, 16'h0);
    chk("reset_running", running, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_fault", fault, 1'b0);
    chk("reset_retire", retire, 1'b0);
    chk("reset_count", instr_count, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven program flow.
    for (int i = 0; i < 32; i++) begin
      start = vecs[i].start; stall = vecs[i].stall; opcode = vecs[i].op;
      target = vecs[i].tgt; eq = vecs[i].eq; lt = vecs[i].lt;
      #1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_running", i), running, vecs[i].e_run);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_retire", i), retire, vecs[i].e_ret);
      chk($sformatf("v%0d_count", i), instr_count, vecs[i].e_cnt);
      chk($sformatf("v%0d_fault", i), fault, vecs[i].e_flt);
      @(negedge clk);
    end

    // Async reset mid-run: reach pc=4, drop reset between edges.
    start = 1'b1; stall = 1'b0; opcode = 4'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_pc_before", pc, 16'h4);
    // start while running has no effect on pc.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_run_pc", pc, 16'h5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_pc", pc, 16'h0);
    chk("midrun_rst_running", running, 1'b0);
    chk("midrun_rst_count", instr_count, 16'h0);
    chk("midrun_rst_retire", retire, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", running, 1'b0);

    // Saturation: JMP-to-self for 20 retires; 4-bit counter sticks at 15.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; opcode = JMP; target = 16'h0;
    repeat (20) @(negedge clk);
    chk("sat4_count", cnt4, 4'hF);
    chk("sat4_running", running4, 1'b1);
    chk("sat4_pc", pc4, 4'h0);
    chk("sat4_fault", fault4, 1'b0);
    chk("wide_count_20", instr_count, 16'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
